// File: rtl/sm_debounce_pkg.sv
// Board-level constants shared by the sm_* blocks, plus the edge-pulse encoding
// used by the debouncer.
package sm_board_pkg;

   localparam int unsigned SM_CLK_HZ          = 10_000_000;
   localparam int unsigned SM_DEBOUNCE_MS     = 10;
   localparam int unsigned SM_DEBOUNCE_CYCLES = SM_CLK_HZ / 1000 * SM_DEBOUNCE_MS;

   typedef enum logic [1:0] {
      EDGE_NONE = 2'd0,
      EDGE_RISE = 2'd1,
      EDGE_FALL = 2'd2
   } sm_edge_e;

endpackage

// File: rtl/sm_debounce_if.sv
// Switch-conditioner bus: raw pins towards the debouncer, clean levels and edge
// pulses back out.
interface sm_debounce_if #(
   parameter int unsigned WIDTH = 6
);
   logic [WIDTH-1:0] in;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;

   modport master (output in, input out, input rise, input fall);
   modport slave  (input in, output out, output rise, output fall);
endinterface

// File: rtl/sm_debounce_bit.sv
// One debounced bit: two-flop synchronizer, stability counter, registered level
// and registered rise/fall pulses.
module sm_debounce_bit
   import sm_board_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = SM_DEBOUNCE_CYCLES,
   parameter logic        RESET_VALUE   = 1'b0
) (
   input  logic clkIn,
   input  logic rst_p,
   input  logic in_i,
   output logic out_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned     CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             s1_q, s2_q;
   logic             out_q, out_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rise_q, fall_q;
   sm_edge_e         edge_d;

   // Any sample equal to the current level restarts the count.
   always_comb begin
      cnt_d  = cnt_q;
      out_d  = out_q;
      edge_d = EDGE_NONE;
      if (s2_q == out_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         out_d  = s2_q;
         cnt_d  = '0;
         edge_d = s2_q ? EDGE_RISE : EDGE_FALL;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clkIn or posedge rst_p) begin
      if (rst_p) begin
         s1_q   <= RESET_VALUE;
         s2_q   <= RESET_VALUE;
         out_q  <= RESET_VALUE;
         cnt_q  <= '0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         s1_q   <= in_i;
         s2_q   <= s1_q;
         out_q  <= out_d;
         cnt_q  <= cnt_d;
         rise_q <= (edge_d == EDGE_RISE);
         fall_q <= (edge_d == EDGE_FALL);
      end
   end

   assign out_o  = out_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/sm_debounce.sv
// Multi-bit switch conditioner: WIDTH independent copies of sm_debounce_bit.
module sm_debounce
   import sm_board_pkg::*;
#(
   parameter int unsigned      WIDTH         = 6,
   parameter int unsigned      STABLE_CYCLES = SM_DEBOUNCE_CYCLES,
   parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
   input  logic             clkIn,
   input  logic             rst_p,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sm_debounce_bit #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .RESET_VALUE   (RESET_VALUE[i])
      ) u_bit (
         .clkIn  (clkIn),
         .rst_p  (rst_p),
         .in_i   (in[i]),
         .out_o  (out[i]),
         .rise_o (rise[i]),
         .fall_o (fall[i])
      );
   end

endmodule

// File: tb/tb_sm_debounce.sv
// Directed bench for sm_debounce: a 4-cycle instance with zero reset value and a
// 1-cycle instance with all-ones reset value.
module tb_sm_debounce;

   logic clk;
   logic rst;
   int unsigned vectors;
   int unsigned miscompares;
   int unsigned rise_cnt;
   int unsigned bpat [14];

   sm_debounce_if #(.WIDTH(6)) bus4 ();
   sm_debounce_if #(.WIDTH(6)) bus1 ();

   sm_debounce #(
      .WIDTH         (6),
      .STABLE_CYCLES (4),
      .RESET_VALUE   (6'h00)
   ) u_dut4 (
      .clkIn (clk),
      .rst_p (rst),
      .in    (bus4.in),
      .out   (bus4.out),
      .rise  (bus4.rise),
      .fall  (bus4.fall)
   );

   sm_debounce #(
      .WIDTH         (6),
      .STABLE_CYCLES (1),
      .RESET_VALUE   (6'h3F)
   ) u_dut1 (
      .clkIn (clk),
      .rst_p (rst),
      .in    (bus1.in),
      .out   (bus1.out),
      .rise  (bus1.rise),
      .fall  (bus1.fall)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      bpat        = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};

      // Reset with all inputs high
      rst     = 1'b1;
      bus4.in = 6'h3F;
      bus1.in = 6'h3F;
      step(3);
      chk("rst_out",   bus4.out,  6'h00);
      chk("rst_rise",  bus4.rise, 6'h00);
      chk("rst_fall",  bus4.fall, 6'h00);
      chk("rst_out1",  bus1.out,  6'h3F);
      rst = 1'b0;
      step(5);
      chk("rel_out_e5",  bus4.out,  6'h00);
      chk("rel_rise_e5", bus4.rise, 6'h00);
      step(1);
      chk("rel_out_e6",  bus4.out,  6'h3F);
      chk("rel_rise_e6", bus4.rise, 6'h3F);
      chk("rel_fall_e6", bus4.fall, 6'h00);
      step(1);
      chk("rel_rise_e7", bus4.rise, 6'h00);
      chk("rel_out_e7",  bus4.out,  6'h3F);
      chk("rel_rise1",   bus1.rise, 6'h00);
      chk("rel_fall1",   bus1.fall, 6'h00);
      bus4.in = 6'h00;
      step(6);
      chk("all_fall_e6", bus4.fall, 6'h3F);
      chk("all_out_e6",  bus4.out,  6'h00);
      step(1);
      chk("all_fall_e7", bus4.fall, 6'h00);

      // Clean edge on bit 0, both directions
      bus4.in = 6'h01;
      for (int k = 1; k <= 5; k++) begin
         step(1);
         chk("clean_out_pre",  bus4.out,  6'h00);
         chk("clean_rise_pre", bus4.rise, 6'h00);
         chk("clean_fall_pre", bus4.fall, 6'h00);
      end
      step(1);
      chk("clean_out_e6",  bus4.out,  6'h01);
      chk("clean_rise_e6", bus4.rise, 6'h01);
      chk("clean_fall_e6", bus4.fall, 6'h00);
      step(1);
      chk("clean_rise_e7", bus4.rise, 6'h00);
      chk("clean_out_e7",  bus4.out,  6'h01);
      bus4.in = 6'h00;
      step(5);
      chk("cfall_out_e5",  bus4.out,  6'h01);
      chk("cfall_fall_e5", bus4.fall, 6'h00);
      step(1);
      chk("cfall_fall_e6", bus4.fall, 6'h01);
      chk("cfall_out_e6",  bus4.out,  6'h00);
      chk("cfall_rise_e6", bus4.rise, 6'h00);
      step(1);
      chk("cfall_fall_e7", bus4.fall, 6'h00);

      // Bounce on bit 2: acceptance at edge 11
      rise_cnt = 0;
      for (int k = 1; k <= 14; k++) begin
         bus4.in = (bpat[k-1] != 0) ? 6'h04 : 6'h00;
         step(1);
         rise_cnt += int'(bus4.rise[2]);
         chk("bounce_out",  bus4.out,  (k >= 11) ? 6'h04 : 6'h00);
         chk("bounce_rise", bus4.rise, (k == 11) ? 6'h04 : 6'h00);
         chk("bounce_fall", bus4.fall, 6'h00);
      end
      chk("bounce_pulses", 6'(rise_cnt), 6'd1);
      bus4.in = 6'h00;
      step(8);
      chk("bounce_clear", bus4.out, 6'h00);

      // Three-cycle glitch on bit 3
      for (int k = 1; k <= 12; k++) begin
         bus4.in = (k <= 3) ? 6'h08 : 6'h00;
         step(1);
         chk("glitch_out",  bus4.out,  6'h00);
         chk("glitch_edge", bus4.rise | bus4.fall, 6'h00);
      end

      // Reset pulse mid-count on bit 1
      bus4.in = 6'h02;
      step(3);
      rst = 1'b1;
      #1;
      chk("midrst_async", bus4.out, 6'h00);
      step(1);
      chk("midrst_out",  bus4.out,  6'h00);
      chk("midrst_rise", bus4.rise, 6'h00);
      chk("midrst_fall", bus4.fall, 6'h00);
      rst = 1'b0;
      step(5);
      chk("midrst_out_e5",  bus4.out,  6'h00);
      chk("midrst_rise_e5", bus4.rise, 6'h00);
      step(1);
      chk("midrst_out_e6",  bus4.out,  6'h02);
      chk("midrst_rise_e6", bus4.rise, 6'h02);
      step(1);
      chk("midrst_rise_e7", bus4.rise, 6'h00);
      bus4.in = 6'h00;
      step(8);
      chk("midrst_clear", bus4.out, 6'h00);

      // Simultaneous change on bits 4 and 5
      bus4.in = 6'h30;
      step(5);
      chk("dual_out_e5",  bus4.out,  6'h00);
      step(1);
      chk("dual_out_e6",  bus4.out,  6'h30);
      chk("dual_rise_e6", bus4.rise, 6'h30);
      bus4.in = 6'h00;
      step(6);
      chk("dual_fall_e6", bus4.fall, 6'h30);
      chk("dual_out_f6",  bus4.out,  6'h00);

      // Single-cycle threshold: three-edge latency
      bus1.in = 6'h3E;
      step(2);
      chk("sc1_out_e2",  bus1.out,  6'h3F);
      chk("sc1_fall_e2", bus1.fall, 6'h00);
      step(1);
      chk("sc1_out_e3",  bus1.out,  6'h3E);
      chk("sc1_fall_e3", bus1.fall, 6'h01);
      chk("sc1_rise_e3", bus1.rise, 6'h00);
      step(1);
      chk("sc1_fall_e4", bus1.fall, 6'h00);
      bus1.in = 6'h3F;
      step(2);
      chk("sc1_rout_e2", bus1.out,  6'h3E);
      step(1);
      chk("sc1_rout_e3", bus1.out,  6'h3F);
      chk("sc1_rise_r3", bus1.rise, 6'h01);
      step(1);
      chk("sc1_rise_r4", bus1.rise, 6'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
